ycbcr_hup2x: RTL
================

Name: ycbcr_hup2x

Overview:
- Horizontal 2x linear upsampler on the YCbCr 4:4:4 pixel stream.
- Sits directly downstream of the RGB->YCbCr converter and upstream of the YCbCr->RGB converter in the upsampling datapath.
- Each input pixel produces two output pixels: the original, then the rounded mean of it and the next pixel on the line. The last pixel of a line is replicated.
- Valid/ready stream on both sides; a single holding register; the output is registered.

Parameters:
- YCbCr_WIDTH, 12, bits per component (Y, Cb, Cr).
- PIX_W, 3*YCbCr_WIDTH, derived localparam, not overridable; packing is {Y,Cb,Cr}, Y in the MSBs.

Ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- in_data  in  PIX_W  input pixel.
- in_valid  in  1  input pixel valid.
- in_eol  in  1  marks the last pixel of a line; qualified by in_valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  PIX_W  output pixel, registered.
- out_valid  out  1  output valid, registered.
- out_eol  out  1  marks the last output pixel of a line.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - ofree = !out_valid | out_ready.
- Reset (sync, rst=1):
  - out_valid=0, out_data=0, out_eol=0.
  - state=S_IDLE; hold and last cleared.
  - Any held pixel is dropped; no partial line is resumed.
- Registers:
  - hold (PIX_W).
  - last (1b): eol flag of hold.
  - state in {S_IDLE, S_WAIT, S_PEND}.
- S_IDLE:
  - in_ready=ofree.
  - On input transfer: hold<=in_data, last<=in_eol, out_data<=in_data, out_eol<=0, out_valid<=1, ->S_WAIT.
  - Else, if out_ready: out_valid<=0.
- S_WAIT (original already emitted):
  - If last=1: in_ready=0. When ofree: out_data<=hold, out_eol<=1, out_valid<=1, ->S_IDLE (replication).
  - If last=0: in_ready=ofree. On input transfer of B: out_data<=avg(hold,B), out_eol<=0, out_valid<=1, hold<=B, last<=in_eol, ->S_PEND.
  - Otherwise, if out_ready: out_valid<=0.
- S_PEND:
  - in_ready=0.
  - When ofree: out_data<=hold, out_eol<=0, out_valid<=1, ->S_WAIT.
- Output stalls: out_data, out_valid and out_eol stay stable while out_valid & !out_ready.
- in_ready is combinational from state and out_ready only; it never depends on in_valid.
- avg, per component: (a+b+1)>>1, computed at YCbCr_WIDTH+1 bits, result truncated to YCbCr_WIDTH. No overflow is possible.
- Latency: input transfer at cycle t -> its first output valid at t+1.
- Throughput: steady state is 1 output per cycle and 1 input per 2 cycles.
- Output count per line: 2N outputs for N inputs. N=1 gives p0, p0(eol).
- in_eol with in_valid=0 is ignored.
- in_eol asserted on consecutive pixels gives lines of length 1.

Optional Feature:
- Macro: YCBCR_HUP2X_SOF_EN.
- Defined:
  - Adds ports in_sof (in, 1) and out_sof (out, 1, registered, reset 0).
  - in_sof is latched with the accepted pixel.
  - out_sof=1 only on the first output generated from an sof-marked pixel (the original), 0 on its average and replica.
- Undefined: ports absent; no start-of-frame tracking logic.

Decomposition:
- Shared package:
  - State encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_PEND=2'd2.
  - Default YCbCr_WIDTH=12.
  - Component slice helper constants for the {Y,Cb,Cr} packing.
- Sub-module: ycbcr_avg2 (combinational per-pixel rounded average, 3 component adders). It is reused by later vertical-upsampling stages.

Test Plan:
- Line of 3 pixels, Y=100,200,50 (Cb=Cr=2048 constant), out_ready=1 -> out Y=100,150,200,125,50,50; out_eol only on the 6th; Cb/Cr=2048 throughout.
- Rounding/limits: Y pair 100,101 -> mid 101; 4095,4095 -> 4095; 0,1 -> 1; Cb 0,4095 -> 2048.
- Single-pixel line: p0={Y=7,Cb=8,Cr=9} with in_eol -> exactly two outputs, both {7,8,9}, second with out_eol=1; then in_ready returns high.
- Backpressure: out_ready low 5 cycles mid-line -> out_data/out_valid/out_eol frozen, in_ready=0, no pixel lost or duplicated; sequence identical to the unstalled run.
- Reset mid-line: assert rst while in S_PEND -> next cycle out_valid=0, in_ready=1; a new 2-pixel line yields 4 correct outputs with no stale hold data.
- With YCBCR_HUP2X_SOF_EN: in_sof on p0 of a 2-pixel line -> out_sof=1 on output 1 only, 0 on outputs 2-4.

Source files
------------

// File: rtl/ycbcr_hup2x_pkg.sv
// rtl/ycbcr_hup2x_pkg.sv - shared constants and types for the horizontal 2x YCbCr upsampler
//
// Purpose : state encoding, default component width and {Y,Cb,Cr} packing helpers
//           used by ycbcr_hup2x and ycbcr_avg2 (and later vertical stages).
package ycbcr_hup2x_pkg;

  localparam int YCBCR_WIDTH_DEF = 12;
  localparam int NUM_COMP        = 3;

  // Component positions inside a packed pixel; Y sits in the MSBs.
  localparam int COMP_Y  = 2;
  localparam int COMP_CB = 1;
  localparam int COMP_CR = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PEND = 2'd2
  } state_t;

  // LSB position of component 'comp' in a pixel of 'width'-bit components.
  function automatic int comp_lsb(input int comp, input int width);
    return comp * width;
  endfunction

endpackage

// File: rtl/ycbcr_avg2.sv
// rtl/ycbcr_avg2.sv - combinational per-component rounded mean of two packed YCbCr pixels
//
// Purpose : avg = (a + b + 1) >> 1 for each of Y, Cb, Cr, evaluated one bit wider
//           than a component so the carry is never lost.
// Ports   : a, b  - packed {Y,Cb,Cr} pixels
//           avg   - packed rounded mean
module ycbcr_avg2
  import ycbcr_hup2x_pkg::*;
#(
  parameter int  W  = YCBCR_WIDTH_DEF,
  localparam int PW = NUM_COMP * W
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] avg
);

  for (genvar c = 0; c < NUM_COMP; c++) begin : g_comp
    logic [W:0] sum;
    assign sum = {1'b0, a[comp_lsb(c, W) +: W]}
               + {1'b0, b[comp_lsb(c, W) +: W]}
               + {{W{1'b0}}, 1'b1};
    // Max sum is 2^(W+1)-1, so the shifted result always fits in W bits.
    assign avg[comp_lsb(c, W) +: W] = W'(sum >> 1);
  end

endmodule

// File: rtl/ycbcr_hup2x.sv
// rtl/ycbcr_hup2x.sv - horizontal 2x linear upsampler for a YCbCr 4:4:4 pixel stream
//
// Purpose : every input pixel yields two outputs: the pixel itself, then the
//           rounded mean of it and the next pixel of the line. The last pixel
//           of a line is replicated and that replica carries out_eol.
// Ports   : clk, rst (synchronous, active-high)
//           in_data/in_valid/in_eol/in_ready    - input pixel stream
//           out_data/out_valid/out_eol/out_ready - registered output stream
//           in_sof/out_sof                        - only with YCBCR_HUP2X_SOF_EN
// Macro   : YCBCR_HUP2X_SOF_EN adds start-of-frame propagation.
module ycbcr_hup2x
  import ycbcr_hup2x_pkg::*;
#(
  parameter int  YCbCr_WIDTH = YCBCR_WIDTH_DEF,
  localparam int PIX_W       = NUM_COMP * YCbCr_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_eol,
`ifdef YCBCR_HUP2X_SOF_EN
  input  logic             in_sof,
  output logic             out_sof,
`endif
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_eol,
  input  logic             out_ready
);

  state_t           state, state_n;
  logic [PIX_W-1:0] hold;
  logic             last;
  logic [PIX_W-1:0] avg_pix;
  logic [PIX_W-1:0] out_data_n;
  logic             out_eol_n;
  logic             ofree;
  logic             out_load;
  logic             out_clear;
  logic             hold_load;
`ifdef YCBCR_HUP2X_SOF_EN
  logic             hold_sof;
  logic             out_sof_n;
`endif

  // The output register can take a new value when empty or being drained.
  assign ofree = !out_valid || out_ready;

  ycbcr_avg2 #(.W(YCbCr_WIDTH)) u_avg (
    .a   (hold),
    .b   (in_data),
    .avg (avg_pix)
  );

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    hold_load  = 1'b0;
    out_data_n = out_data;
    out_eol_n  = 1'b0;
`ifdef YCBCR_HUP2X_SOF_EN
    out_sof_n  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        in_ready = ofree;
        if (in_valid && ofree) begin
          out_load   = 1'b1;
          hold_load  = 1'b1;
          out_data_n = in_data;
`ifdef YCBCR_HUP2X_SOF_EN
          out_sof_n  = in_sof;
`endif
          state_n    = S_WAIT;
        end else if (out_ready) begin
          out_clear = 1'b1;
        end
      end
      S_WAIT: begin
        if (last) begin
          // End of line: emit the replica without consuming input.
          if (ofree) begin
            out_load   = 1'b1;
            out_data_n = hold;
            out_eol_n  = 1'b1;
            state_n    = S_IDLE;
          end
        end else begin
          in_ready = ofree;
          if (in_valid && ofree) begin
            out_load   = 1'b1;
            hold_load  = 1'b1;
            out_data_n = avg_pix;
            state_n    = S_PEND;
          end else if (out_ready) begin
            out_clear = 1'b1;
          end
        end
      end
      S_PEND: begin
        // The pixel just absorbed into hold still owes its original output.
        if (ofree) begin
          out_load   = 1'b1;
          out_data_n = hold;
`ifdef YCBCR_HUP2X_SOF_EN
          out_sof_n  = hold_sof;
`endif
          state_n    = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      last      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
`ifdef YCBCR_HUP2X_SOF_EN
      hold_sof  <= 1'b0;
      out_sof   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (hold_load) begin
        hold <= in_data;
        last <= in_eol;
`ifdef YCBCR_HUP2X_SOF_EN
        hold_sof <= in_sof;
`endif
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= out_data_n;
        out_eol   <= out_eol_n;
`ifdef YCBCR_HUP2X_SOF_EN
        out_sof   <= out_sof_n;
`endif
      end else if (out_clear) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
